// File: rtl/shift_operand_decoder.sv
// Operand-2 front end for the data-processing path.
// Decodes the immediate-rotate, immediate-shift and register-shift forms of
// operand 2, fetches Rs for register-specified shifts, and hands the barrel
// shifter a canonical request in which every zero-amount special case has
// already been resolved.
module shift_operand_decoder #(
    parameter int RS_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_imm,
    input  logic [11:0] i_operand2,
    input  logic [31:0] i_rm_data,
    input  logic        i_carry,
    input  logic        i_flush,
    output logic        o_rs_rd,
    output logic [3:0]  o_rs_addr,
    input  logic [31:0] i_rs_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_shift_op,
    output logic [2:0]  o_shift_type,
    output logic [7:0]  o_shift_amount,
    output logic        o_shift_carry
);

    // The capture state assumes Rs arrives exactly one cycle after the strobe.
    if (RS_LATENCY != 1) begin : g_rs_latency_check
        $error("shift_operand_decoder: only RS_LATENCY = 1 is supported");
    end

    localparam logic [2:0] SH_LSL    = 3'd0;
    localparam logic [2:0] SH_LSR    = 3'd1;
    localparam logic [2:0] SH_ASR    = 3'd2;
    localparam logic [2:0] SH_ROR    = 3'd3;
    localparam logic [2:0] SH_RRX    = 3'd4;
    localparam logic [2:0] SH_BYPASS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RS_RD  = 2'd1,
        ST_RS_CAP = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] op;
        logic [2:0]  kind;
        logic [7:0]  amount;
        logic        carry;
    } shift_req_t;

    localparam shift_req_t REQ_RESET = '{op: 32'd0, kind: SH_BYPASS, amount: 8'd0, carry: 1'b0};

    // Immediate-rotate and immediate-shift forms: everything is known at accept.
    function automatic shift_req_t decode_static(
        input logic        imm,
        input logic [11:0] op2,
        input logic [31:0] rm,
        input logic        c
    );
        shift_req_t r;
        r.op     = rm;
        r.kind   = SH_BYPASS;
        r.amount = 8'd0;
        r.carry  = c;
        if (imm) begin
            r.op = {24'd0, op2[7:0]};
            if (op2[11:8] == 4'd0) begin
                r.kind   = SH_BYPASS;
                r.amount = 8'd0;
            end else begin
                r.kind   = SH_ROR;
                r.amount = {3'd0, op2[11:8], 1'b0};
            end
        end else if (op2[11:7] == 5'd0) begin
            // A zero shift field encodes the architectural special cases.
            case (op2[6:5])
                2'd0: begin r.kind = SH_BYPASS; r.amount = 8'd0;  end
                2'd1: begin r.kind = SH_LSR;    r.amount = 8'd32; end
                2'd2: begin r.kind = SH_ASR;    r.amount = 8'd32; end
                2'd3: begin r.kind = SH_RRX;    r.amount = 8'd1;  end
                default: begin r.kind = SH_BYPASS; r.amount = 8'd0; end
            endcase
        end else begin
            r.kind   = {1'b0, op2[6:5]};
            r.amount = {3'd0, op2[11:7]};
        end
        return r;
    endfunction

    // Register-shift form, evaluated once the low byte of Rs is available.
    function automatic shift_req_t decode_reg(
        input logic [1:0]  sh,
        input logic [7:0]  amt,
        input logic [31:0] rm,
        input logic        c
    );
        shift_req_t r;
        r.op     = rm;
        r.kind   = SH_BYPASS;
        r.amount = 8'd0;
        r.carry  = c;
        if (amt == 8'd0) begin
            r.kind   = SH_BYPASS;
            r.amount = 8'd0;
        end else if (sh != 2'd3) begin
            r.kind   = {1'b0, sh};
            r.amount = amt;
        end else if (amt[4:0] == 5'd0) begin
            // Rotate by a non-zero multiple of 32: value unchanged, carry is bit 31.
            r.kind   = SH_BYPASS;
            r.amount = 8'd0;
            r.carry  = rm[31];
        end else begin
            r.kind   = SH_ROR;
            r.amount = {3'd0, amt[4:0]};
        end
        return r;
    endfunction

    state_t      state_r,   state_next_s;
    logic        valid_r,   valid_next_s;
    logic        rs_rd_r,   rs_rd_next_s;
    logic [3:0]  rs_addr_r, rs_addr_next_s;
    shift_req_t  req_r,     req_next_s;
    logic [31:0] rm_r,      rm_next_s;
    logic        carry_r,   carry_next_s;
    logic [1:0]  sh_r,      sh_next_s;

    logic        accept_s;
    logic        reg_form_s;
    shift_req_t  static_req_s;
    logic        unused_rs_hi_s;

    assign o_ready = ~i_flush & ((state_r == ST_IDLE) | ((state_r == ST_OUT) & i_ready));
    assign accept_s       = i_valid & o_ready;
    assign reg_form_s     = ~i_imm & i_operand2[4];
    assign static_req_s   = decode_static(i_imm, i_operand2, i_rm_data, i_carry);
    assign unused_rs_hi_s = ^i_rs_data[31:8];

    assign o_valid        = valid_r;
    assign o_rs_rd        = rs_rd_r;
    assign o_rs_addr      = rs_addr_r;
    assign o_shift_op     = req_r.op;
    assign o_shift_type   = req_r.kind;
    assign o_shift_amount = req_r.amount;
    assign o_shift_carry  = req_r.carry;

    // Next-state and next-output logic; loading a request from OUT behaves as from IDLE.
    always_comb begin
        state_next_s   = state_r;
        valid_next_s   = valid_r;
        rs_rd_next_s   = 1'b0;
        rs_addr_next_s = rs_addr_r;
        req_next_s     = req_r;
        rm_next_s      = rm_r;
        carry_next_s   = carry_r;
        sh_next_s      = sh_r;
        if (i_flush) begin
            state_next_s = ST_IDLE;
            valid_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_next_s   = reg_form_s ? ST_RS_RD : ST_OUT;
                        valid_next_s   = ~reg_form_s;
                        rs_rd_next_s   = reg_form_s;
                        rs_addr_next_s = reg_form_s ? i_operand2[11:8] : rs_addr_r;
                        req_next_s     = reg_form_s ? req_r : static_req_s;
                        rm_next_s      = i_rm_data;
                        carry_next_s   = i_carry;
                        sh_next_s      = i_operand2[6:5];
                    end else begin
                        state_next_s = ST_IDLE;
                        valid_next_s = 1'b0;
                    end
                end
                ST_RS_RD: begin
                    state_next_s = ST_RS_CAP;
                    valid_next_s = 1'b0;
                end
                ST_RS_CAP: begin
                    state_next_s = ST_OUT;
                    valid_next_s = 1'b1;
                    req_next_s   = decode_reg(sh_r, i_rs_data[7:0], rm_r, carry_r);
                end
                ST_OUT: begin
                    if (!i_ready) begin
                        state_next_s = ST_OUT;
                        valid_next_s = 1'b1;
                    end else if (accept_s) begin
                        state_next_s   = reg_form_s ? ST_RS_RD : ST_OUT;
                        valid_next_s   = ~reg_form_s;
                        rs_rd_next_s   = reg_form_s;
                        rs_addr_next_s = reg_form_s ? i_operand2[11:8] : rs_addr_r;
                        req_next_s     = reg_form_s ? req_r : static_req_s;
                        rm_next_s      = i_rm_data;
                        carry_next_s   = i_carry;
                        sh_next_s      = i_operand2[6:5];
                    end else begin
                        state_next_s = ST_IDLE;
                        valid_next_s = 1'b0;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            rs_rd_r   <= 1'b0;
            rs_addr_r <= 4'd0;
            req_r     <= REQ_RESET;
            rm_r      <= 32'd0;
            carry_r   <= 1'b0;
            sh_r      <= 2'd0;
        end else begin
            state_r   <= state_next_s;
            valid_r   <= valid_next_s;
            rs_rd_r   <= rs_rd_next_s;
            rs_addr_r <= rs_addr_next_s;
            req_r     <= req_next_s;
            rm_r      <= rm_next_s;
            carry_r   <= carry_next_s;
            sh_r      <= sh_next_s;
        end
    end

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Self-checking bench for shift_operand_decoder: directed vector table,
// randomized requests against a rule-level reference model, and hand-written
// stall / back-to-back / flush / reset sequences.
module tb_shift_operand_decoder;

    logic        clk = 1'b0;
    logic        i_rst_n, i_valid, i_imm, i_carry, i_flush, i_ready;
    logic [11:0] i_operand2;
    logic [31:0] i_rm_data, i_rs_data;
    logic        o_ready, o_rs_rd, o_valid, o_shift_carry;
    logic [3:0]  o_rs_addr;
    logic [31:0] o_shift_op;
    logic [2:0]  o_shift_type;
    logic [7:0]  o_shift_amount;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_operand_decoder #(.RS_LATENCY(1)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_imm(i_imm), .i_operand2(i_operand2), .i_rm_data(i_rm_data),
        .i_carry(i_carry), .i_flush(i_flush), .o_rs_rd(o_rs_rd),
        .o_rs_addr(o_rs_addr), .i_rs_data(i_rs_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_shift_op(o_shift_op), .o_shift_type(o_shift_type),
        .o_shift_amount(o_shift_amount), .o_shift_carry(o_shift_carry)
    );

    typedef struct {
        logic        imm;
        logic [11:0] op2;
        logic [31:0] rm;
        logic        c;
        logic [31:0] rs;
        logic [31:0] e_op;
        logic [2:0]  e_typ;
        logic [7:0]  e_amt;
        logic        e_c;
        int          e_lat;
        int          stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural operand-2 rules written as plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int rot, n, sh, a;
        r.e_c = v.c;
        if (v.imm) begin
            rot     = int'(v.op2[11:8]);
            r.e_op  = 32'(v.op2 & 12'hFF);
            r.e_typ = (rot == 0) ? 3'd7 : 3'd3;
            r.e_amt = 8'(rot * 2);
            r.e_lat = 1;
        end else if (v.op2[4] == 1'b0) begin
            n = int'(v.op2[11:7]);
            sh = int'(v.op2[6:5]);
            r.e_op = v.rm;
            r.e_lat = 1;
            if (n != 0)       begin r.e_typ = 3'(sh); r.e_amt = 8'(n);  end
            else if (sh == 0) begin r.e_typ = 3'd7;   r.e_amt = 8'd0;   end
            else if (sh == 3) begin r.e_typ = 3'd4;   r.e_amt = 8'd1;   end
            else              begin r.e_typ = 3'(sh); r.e_amt = 8'd32;  end
        end else begin
            a = int'(v.rs[7:0]);
            sh = int'(v.op2[6:5]);
            r.e_op = v.rm;
            r.e_lat = 3;
            if (a == 0)           begin r.e_typ = 3'd7; r.e_amt = 8'd0; end
            else if (sh != 3)     begin r.e_typ = 3'(sh); r.e_amt = 8'(a); end
            else if (a % 32 == 0) begin r.e_typ = 3'd7; r.e_amt = 8'd0; r.e_c = v.rm[31]; end
            else                  begin r.e_typ = 3'd3; r.e_amt = 8'(a % 32); end
        end
        return r;
    endfunction

    task automatic chk_fields(input string tag, input vec_t v);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_op"}, o_shift_op, v.e_op);
        chk({tag, "_type"}, 32'(o_shift_type), 32'(v.e_typ));
        chk({tag, "_amount"}, 32'(o_shift_amount), 32'(v.e_amt));
        chk({tag, "_carry"}, 32'(o_shift_carry), 32'(v.e_c));
    endtask

    // Issue one request from IDLE, serve the Rs port, check latency, fields and hold.
    task automatic run_one(input vec_t v);
        int  lat;
        bit  prev_rd, seen_rd, done;
        @(negedge clk);
        i_valid = 1'b1; i_imm = v.imm; i_operand2 = v.op2; i_rm_data = v.rm;
        i_carry = v.c; i_ready = 1'b0; i_rs_data = $urandom;
        #1 chk("ready_idle", 32'(o_ready), 32'd1);
        @(negedge clk);
        i_valid = 1'b0; i_imm = 1'($urandom_range(0, 1)); i_operand2 = 12'($urandom);
        i_rm_data = ~v.rm; i_carry = ~v.c;
        prev_rd = 1'b0; seen_rd = 1'b0; done = 1'b0; lat = 1;
        while (!done && lat <= 8) begin
            i_rs_data = prev_rd ? v.rs : $urandom;
            prev_rd = o_rs_rd;
            if (o_rs_rd) begin
                seen_rd = 1'b1;
                chk("rs_addr", 32'(o_rs_addr), 32'(v.op2[11:8]));
            end
            if (o_valid) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL timeout: no o_valid within 8 cycles for operand2=0x%03h", v.op2);
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
        end else begin
            chk("latency", 32'(lat), 32'(v.e_lat));
            chk("rs_rd_seen", 32'(seen_rd), 32'(v.e_lat == 3));
            for (int s = 0; s <= v.stall; s++) begin
                chk_fields("hold", v);
                if (s < v.stall) begin
                    chk("ready_stall", 32'(o_ready), 32'd0);
                    @(negedge clk);
                end
            end
            i_ready = 1'b1;
            #1 chk("ready_consume", 32'(o_ready), 32'd1);
            @(negedge clk);
            i_ready = 1'b0;
            chk("valid_drop", 32'(o_valid), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_rs_rd"}, 32'(o_rs_rd), 32'd0);
        chk({tag, "_rs_addr"}, 32'(o_rs_addr), 32'd0);
        chk({tag, "_op"}, o_shift_op, 32'd0);
        chk({tag, "_type"}, 32'(o_shift_type), 32'd7);
        chk({tag, "_amount"}, 32'(o_shift_amount), 32'd0);
        chk({tag, "_carry"}, 32'(o_shift_carry), 32'd0);
    endtask

    vec_t vecs[14];
    vec_t rv;

    initial begin
        //        imm  op2      rm            c     rs            e_op          typ   amt    c     lat stall
        vecs[0]  = '{1'b1, 12'h4FF, 32'h12345678, 1'b1, 32'h0,        32'h000000FF, 3'd3, 8'd8,  1'b1, 1, 0};
        vecs[1]  = '{1'b1, 12'h0A5, 32'hDEADBEEF, 1'b0, 32'h0,        32'h000000A5, 3'd7, 8'd0,  1'b0, 1, 1};
        vecs[2]  = '{1'b0, 12'h020, 32'h80000000, 1'b0, 32'h0,        32'h80000000, 3'd1, 8'd32, 1'b0, 1, 0};
        vecs[3]  = '{1'b0, 12'h060, 32'h00000003, 1'b1, 32'h0,        32'h00000003, 3'd4, 8'd1,  1'b1, 1, 0};
        vecs[4]  = '{1'b0, 12'h331, 32'hF0000000, 1'b0, 32'h00000120, 32'hF0000000, 3'd1, 8'h20, 1'b0, 3, 2};
        vecs[5]  = '{1'b0, 12'h371, 32'hF0000000, 1'b0, 32'h00000120, 32'hF0000000, 3'd7, 8'd0,  1'b1, 3, 0};
        vecs[6]  = '{1'b0, 12'h271, 32'h80000001, 1'b0, 32'h00000040, 32'h80000001, 3'd7, 8'd0,  1'b1, 3, 0};
        vecs[7]  = '{1'b0, 12'h271, 32'h80000001, 1'b0, 32'hFFFFFF00, 32'h80000001, 3'd7, 8'd0,  1'b0, 3, 0};
        vecs[8]  = '{1'b0, 12'h000, 32'h12345678, 1'b1, 32'h0,        32'h12345678, 3'd7, 8'd0,  1'b1, 1, 0};
        vecs[9]  = '{1'b0, 12'h040, 32'h80000000, 1'b0, 32'h0,        32'h80000000, 3'd2, 8'd32, 1'b0, 1, 0};
        vecs[10] = '{1'b0, 12'h280, 32'h0000F00F, 1'b1, 32'h0,        32'h0000F00F, 3'd0, 8'd5,  1'b1, 1, 0};
        vecs[11] = '{1'b0, 12'h411, 32'h00000001, 1'b1, 32'h000001C8, 32'h00000001, 3'd0, 8'd200, 1'b1, 3, 0};
        vecs[12] = '{1'b0, 12'h271, 32'hA5A5A5A5, 1'b0, 32'h00000125, 32'hA5A5A5A5, 3'd3, 8'd5,  1'b0, 3, 0};
        vecs[13] = '{1'b1, 12'hF01, 32'h0,        1'b1, 32'h0,        32'h00000001, 3'd3, 8'd30, 1'b1, 1, 0};

        i_rst_n = 1'b0; i_valid = 1'b0; i_imm = 1'b0; i_operand2 = 12'h0;
        i_rm_data = 32'h0; i_carry = 1'b0; i_flush = 1'b0; i_ready = 1'b0; i_rs_data = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_one(vecs[i]);

        // Stall then back-to-back immediates, one result per cycle.
        @(negedge clk);
        i_valid = 1'b1; i_imm = 1'b1; i_operand2 = 12'h1FF; i_carry = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk("b2b_hold_type", 32'(o_shift_type), 32'd3);
            chk("b2b_hold_amt", 32'(o_shift_amount), 32'd2);
            chk("b2b_hold_ready", 32'(o_ready), 32'd0);
            @(negedge clk);
        end
        i_ready = 1'b1; i_valid = 1'b1; i_operand2 = 12'h0C3; i_carry = 1'b1;
        #1 chk("b2b_ready1", 32'(o_ready), 32'd1);
        @(negedge clk);
        chk("b2b_op1", o_shift_op, 32'h000000C3);
        chk("b2b_type1", 32'(o_shift_type), 32'd7);
        chk("b2b_carry1", 32'(o_shift_carry), 32'd1);
        i_operand2 = 12'h210; i_carry = 1'b0;
        #1 chk("b2b_ready2", 32'(o_ready), 32'd1);
        @(negedge clk);
        chk("b2b_valid2", 32'(o_valid), 32'd1);
        chk("b2b_op2", o_shift_op, 32'h00000010);
        chk("b2b_amt2", 32'(o_shift_amount), 32'd4);
        i_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // Flush during the Rs read, with a competing request that must be refused.
        @(negedge clk);
        i_valid = 1'b1; i_imm = 1'b0; i_operand2 = 12'h371; i_rm_data = 32'h1; i_carry = 1'b0;
        @(negedge clk);
        chk("flush_rs_rd", 32'(o_rs_rd), 32'd1);
        i_flush = 1'b1; i_imm = 1'b1; i_operand2 = 12'h4FF;
        #1 chk("flush_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_rs_rd_drop", 32'(o_rs_rd), 32'd0);
        for (int s = 0; s < 4; s++) begin
            chk("flush_no_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
        end
        #1 chk("flush_idle", 32'(o_ready), 32'd1);

        // Reset while a result is being offered.
        @(negedge clk);
        i_valid = 1'b1; i_imm = 1'b1; i_operand2 = 12'h4FF; i_carry = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rst_out_valid", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_out");
        i_rst_n = 1'b1;

        // Reset during the Rs read discards the request.
        @(negedge clk);
        i_valid = 1'b1; i_imm = 1'b0; i_operand2 = 12'h331; i_rs_data = 32'h5;
        @(negedge clk);
        i_valid = 1'b0; i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_rs_no_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
        end

        // Randomized requests against the reference model.
        for (int i = 0; i < 80; i++) begin
            rv.imm = 1'($urandom_range(0, 1));
            rv.op2 = 12'($urandom);
            rv.rm  = $urandom;
            rv.c   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rv.rs = {24'($urandom), 8'h00};
                1:       rv.rs = {24'($urandom), 3'($urandom), 5'd0};
                default: rv.rs = $urandom;
            endcase
            rv.stall = $urandom_range(0, 2);
            rv = model(rv);
            run_one(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
